// File: rtl/trap_ctrl.sv
// trap_ctrl
// Trap sequencer between the core pipeline and the machine-mode CSR unit.
// It arbitrates synchronous exceptions, level interrupts and mret. On trap
// entry it writes mepc and mcause through the CSR unit's direct write ports,
// then redirects fetch to the trap vector. On mret it redirects fetch to mepc.
//
// Optional feature macro: TRAP_CTRL_VECTORED_EN
//   defined   - vectored mtvec mode (mtvec[1:0]==1) offsets interrupt targets
//               by 4*cause
//   undefined - mtvec[1:0] is ignored and every trap uses the direct base
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   excValid/excCode/excPc synchronous exception report from the pipeline
//   nextPc                 PC saved as mepc when an interrupt is taken
//   irq, irqEn             level interrupt lines and global enable
//   retValid               mret executed this cycle
//   csrMtvec, csrMepc      current CSR values
//   csrMepcWe/Di           direct mepc write port
//   csrMcauseWe/Di         direct mcause write port
//   stall, flush           pipeline hold and squash
//   redirect, redirectPc   fetch PC redirect
//   inTrap                 handler active, interrupts masked
module trap_ctrl #(
   parameter int NUM_IRQ       = 4,
   parameter int IRQ_BASE_CODE = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               excValid,
   input  logic [3:0]         excCode,
   input  logic [31:0]        excPc,
   input  logic [31:0]        nextPc,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               irqEn,
   input  logic               retValid,
   input  logic [31:0]        csrMtvec,
   input  logic [31:0]        csrMepc,
   output logic               csrMepcWe,
   output logic [31:0]        csrMepcDi,
   output logic               csrMcauseWe,
   output logic [31:0]        csrMcauseDi,
   output logic               stall,
   output logic               flush,
   output logic               redirect,
   output logic [31:0]        redirectPc,
   output logic               inTrap
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SAVE = 2'd1,
      JUMP = 2'd2,
      RET  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [31:0] r_cause;
   logic [31:0] r_pc;
   logic        r_inTrap;
   logic [31:0] w_capCause;
   logic [31:0] w_capPc;
   logic        w_nextInTrap;
   logic        w_irqFound;
   logic [4:0]  w_irqIdx;
   logic [30:0] w_irqCode;
   logic [31:0] w_trapBase;
   logic [31:0] w_trapTarget;

   // Lowest-numbered pending interrupt wins: scan downward so the last hit
   // is the smallest index.
   always_comb begin
      w_irqFound = 1'b0;
      w_irqIdx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq[i]) begin
            w_irqFound = 1'b1;
            w_irqIdx   = 5'(i);
         end
      end
   end

   assign w_irqCode  = 31'(IRQ_BASE_CODE) + 31'(w_irqIdx);
   assign w_trapBase = {csrMtvec[31:2], 2'b00};

`ifdef TRAP_CTRL_VECTORED_EN
   // Only interrupts are vectored; exceptions always land on the base.
   // cause[30:0]<<2 truncated to 32 bits keeps only cause[29:0].
   assign w_trapTarget = (csrMtvec[1:0] == 2'b01 && r_cause[31])
                         ? w_trapBase + {r_cause[29:0], 2'b00}
                         : w_trapBase;
`else
   logic [1:0] w_unusedMtvecMode;
   assign w_unusedMtvecMode = csrMtvec[1:0];
   assign w_trapTarget      = w_trapBase;
`endif

   // Next-state and output decode. Outputs are decodes of the registered
   // state, except stall in IDLE which follows the accept condition so the
   // pipeline freezes in the same cycle the trap is taken.
   always_comb begin
      w_nextState  = r_state;
      w_capCause   = r_cause;
      w_capPc      = r_pc;
      w_nextInTrap = r_inTrap;
      csrMepcWe    = 1'b0;
      csrMepcDi    = '0;
      csrMcauseWe  = 1'b0;
      csrMcauseDi  = '0;
      stall        = 1'b0;
      flush        = 1'b0;
      redirect     = 1'b0;
      redirectPc   = '0;
      unique case (r_state)
         IDLE: begin
            if (excValid) begin
               w_capCause  = {28'b0, excCode};
               w_capPc     = excPc;
               stall       = 1'b1;
               w_nextState = SAVE;
            end else if (irqEn && !r_inTrap && w_irqFound) begin
               w_capCause  = {1'b1, w_irqCode};
               w_capPc     = nextPc;
               stall       = 1'b1;
               w_nextState = SAVE;
            end else if (retValid) begin
               stall       = 1'b1;
               w_nextState = RET;
            end
         end
         SAVE: begin
            csrMepcWe   = 1'b1;
            csrMcauseWe = 1'b1;
            csrMepcDi   = {r_pc[31:2], 2'b00};
            csrMcauseDi = r_cause;
            stall       = 1'b1;
            w_nextState = JUMP;
         end
         JUMP: begin
            redirect     = 1'b1;
            flush        = 1'b1;
            stall        = 1'b1;
            redirectPc   = w_trapTarget;
            w_nextInTrap = 1'b1;
            w_nextState  = IDLE;
         end
         RET: begin
            redirect     = 1'b1;
            flush        = 1'b1;
            stall        = 1'b1;
            redirectPc   = csrMepc;
            w_nextInTrap = 1'b0;
            w_nextState  = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
      // While reset is held nothing may leak out, in particular no CSR write
      // on the edge that aborts a SAVE.
      if (reset) begin
         csrMepcWe   = 1'b0;
         csrMepcDi   = '0;
         csrMcauseWe = 1'b0;
         csrMcauseDi = '0;
         stall       = 1'b0;
         flush       = 1'b0;
         redirect    = 1'b0;
         redirectPc  = '0;
      end
   end

   // State, captured trap cause/pc and handler-active flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cause  <= '0;
         r_pc     <= '0;
         r_inTrap <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cause  <= w_capCause;
         r_pc     <= w_capPc;
         r_inTrap <= w_nextInTrap;
      end
   end

   assign inTrap = r_inTrap;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer sitting between the core pipeline and the machine-mode CSR unit.
- Arbitrates synchronous exceptions, level interrupt lines and mret.
- Drives the CSR unit's direct mepc/mcause write ports in a fixed multi-cycle trap-entry sequence.
- Computes the redirect PC from mtvec (entry) or mepc (return), and stalls/flushes the pipeline while sequencing.

Parameters:
- NUM_IRQ, 4, number of platform interrupt lines (1..16).
- IRQ_BASE_CODE, 16, mcause exception-code of irq[0]; irq[i] uses IRQ_BASE_CODE+i.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- excValid  in  1  pipeline reports a synchronous exception this cycle.
- excCode  in  4  exception cause code (mcause[3:0]).
- excPc  in  32  PC of the faulting instruction.
- nextPc  in  32  PC of next instruction to retire (saved on interrupt).
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- irqEn  in  1  global machine interrupt enable.
- retValid  in  1  mret executed this cycle.
- csrMtvec  in  32  current mtvec from CSR unit.
- csrMepc  in  32  current mepc from CSR unit.
- csrMepcWe  out  1  direct mepc write strobe to CSR unit.
- csrMepcDi  out  32  mepc write data.
- csrMcauseWe  out  1  direct mcause write strobe to CSR unit.
- csrMcauseDi  out  32  mcause write data.
- stall  out  1  hold pipeline (no retire, no fetch advance).
- flush  out  1  squash all in-flight instructions (1-cycle pulse).
- redirect  out  1  load redirectPc into fetch PC (1-cycle pulse).
- redirectPc  out  32  target PC, valid while redirect=1.
- inTrap  out  1  handler active; interrupts masked.

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0, inTrap=0. Captured cause/pc registers cleared to 0.
- States: IDLE, SAVE, JUMP, RET.
- IDLE, evaluated each cycle, in priority order:
  - excValid=1: capture cause={1'b0,27'b0,excCode}, pc=excPc; stall=1 combinationally this cycle; next=SAVE.
  - else irqEn=1, inTrap=0 and |irq: lowest set index i wins; capture cause={1'b1, 31-bit (IRQ_BASE_CODE+i)}, pc=nextPc; stall=1; next=SAVE.
  - else retValid=1: stall=1; next=RET.
  - else: stay IDLE, stall=0.
- Exception beats interrupt and mret in the same cycle. The losing mret is dropped: the pipeline squashes it via flush.
- SAVE (1 cycle): csrMepcWe=1, csrMcauseWe=1, csrMepcDi={pc[31:2],2'b00}, csrMcauseDi=cause, stall=1. next=JUMP.
- JUMP (1 cycle): redirect=1, flush=1, stall=1, inTrap<=1. next=IDLE.
  - Direct (csrMtvec[1:0]=0), or any exception: redirectPc={csrMtvec[31:2],2'b00}.
  - Vectored (csrMtvec[1:0]=1) and cause[31]=1: redirectPc={csrMtvec[31:2],2'b00}+(cause[30:0]<<2), 32-bit wrap on overflow.
- RET (1 cycle): redirect=1, flush=1, stall=1, redirectPc=csrMepc, inTrap<=0. next=IDLE.
- Latency: exception/interrupt accept to redirect = 2 cycles after the accept cycle. mret to redirect = 1 cycle.
- excValid, irq and retValid are ignored in SAVE, JUMP and RET; the pipeline is stalled, so they are not expected.
- Exception while inTrap=1 is taken normally (mepc/mcause overwritten, inTrap stays 1). Interrupts stay masked while inTrap=1.
- irq deasserted after capture: trap still completes with the captured cause.
- reset in any state: returns to IDLE next edge. No CSR write is issued on that edge (strobes forced 0 while reset=1).
- Outputs are registered state decodes, except stall in IDLE, which is combinational from the accept condition.

Optional Feature:
TRAP_CTRL_VECTORED_EN
- Defined: vectored mtvec mode supported as above.
- Undefined: csrMtvec[1:0] is ignored and all traps use the direct base {csrMtvec[31:2],2'b00}. The offset adder is not built.

Test Plan:
- Exception: excValid=1, excCode=2, excPc=0x100, csrMtvec=0x200 → SAVE writes mepc=0x100, mcause=0x00000002; JUMP redirect to 0x200, flush=1, inTrap=1.
- Vectored interrupt: irqEn=1, irq=4'b0110, nextPc=0x44, csrMtvec=0x301 → mcause=0x80000011, mepc=0x44, redirectPc=0x344. Without TRAP_CTRL_VECTORED_EN, redirectPc=0x300.
- Masking: inTrap=1, irq=1 → no trap. mret with csrMepc=0x44 → next cycle redirect to 0x44, inTrap=0. Pending irq is then taken from IDLE.
- Priority: excValid=1 with irq[0]=1, irqEn=1 and retValid=1 in the same cycle → mcause=exception code, mepc=excPc, one trap only.
- Misaligned excPc=0x103 → csrMepcDi=0x100.
- Reset asserted during SAVE → no csrMepcWe/csrMcauseWe pulse; next cycle IDLE, all outputs 0.
